// File: rtl/bitmask_next_popcount_reg.sv
// Registered Gosper's-hack step. It returns the next larger word with the same popcount,
// or wraps to the smallest such word and flags the wrap. The output is one register stage with valid/ready.

module bnp_isolate_rightmost #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);
    assign y_o = a_i & (~a_i + W'(1));
endmodule

module bnp_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);
    logic [W-1:0] b_eff;
    assign b_eff = sub_i ? ~b_i : b_i;
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
endmodule

module bnp_hamming #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] dist_o
);
    logic [W-1:0] diff;
    assign diff = a_i ^ b_i;

    always_comb begin
        dist_o = '0;
        for (int i = 0; i < W; i++)
            dist_o = dist_o + {{(W-1){1'b0}}, diff[i]};
    end
endmodule

module bnp_shifter #(
    parameter int W = 8
) (
    input  logic [W-1:0] amt_i,
    output logic [W-1:0] y_o
);
    localparam logic [W-1:0] W_L = W'(W);
    localparam logic [W-1:0] ONE = W'(1);

    // Shift amounts at or beyond the word width must produce 0.
    assign y_o = (amt_i >= W_L) ? '0 : (ONE << amt_i);
endmodule

module bitmask_next_popcount_reg #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  wrapped
);
    localparam int W = WORD_WIDTH;

    logic [W-1:0] smallest, ripple, changed, adj, shifted, lost, next_w;
    logic         carry, next_wrap;
    logic         unused_adj_c, unused_lost_c;

    bnp_isolate_rightmost #(.W(W)) u_iso (
        .a_i (word_in),
        .y_o (smallest)
    );

    bnp_addsub #(.W(W)) u_ripple (
        .a_i     (word_in),
        .b_i     (smallest),
        .sub_i   (1'b0),
        .sum_o   (ripple),
        .carry_o (carry)
    );

    bnp_hamming #(.W(W)) u_ham (
        .a_i    (word_in),
        .b_i    (ripple),
        .dist_o (changed)
    );

    // The -2 applies only when the ripple stayed inside the word.
    bnp_addsub #(.W(W)) u_adj (
        .a_i     (changed),
        .b_i     (carry ? '0 : W'(2)),
        .sub_i   (1'b1),
        .sum_o   (adj),
        .carry_o (unused_adj_c)
    );

    bnp_shifter #(.W(W)) u_shift (
        .amt_i (adj),
        .y_o   (shifted)
    );

    bnp_addsub #(.W(W)) u_lost (
        .a_i     (shifted),
        .b_i     (W'(1)),
        .sub_i   (1'b1),
        .sum_o   (lost),
        .carry_o (unused_lost_c)
    );

    // A zero word has no successor, so force the result to zero instead of all-ones.
    assign next_w    = (word_in == '0) ? '0 : (ripple | lost);
    assign next_wrap = (word_in != '0) & carry;

    logic         valid_q, valid_d;
    logic [W-1:0] word_q, word_d;
    logic         wrap_q, wrap_d;
    logic         accept;

    assign input_ready = !valid_q | output_ready;
    assign accept      = input_valid & input_ready;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        wrap_d  = wrap_q;
        if (accept) begin
            valid_d = 1'b1;
            word_d  = next_w;
            wrap_d  = next_wrap;
        end else if (output_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            wrap_q  <= wrap_d;
        end
    end

    assign output_valid = valid_q;
    assign word_out     = word_q;
    assign wrapped      = wrap_q;
endmodule

// File: tb/tb_bitmask_next_popcount_reg.sv
// Bench for bitmask_next_popcount_reg (WORD_WIDTH=8): a table of vectors, a feedback chain,
// backpressure and a mid-stream clear. Outputs are checked against a FIFO of expected results.

module tb_bitmask_next_popcount_reg;
    logic       clock, clear, input_valid, input_ready, output_valid, output_ready, wrapped;
    logic [7:0] word_in, word_out;

    bitmask_next_popcount_reg #(.WORD_WIDTH(8)) dut (
        .clock        (clock),
        .clear        (clear),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .word_in      (word_in),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .word_out     (word_out),
        .wrapped      (wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] w;
        logic       wr;
    } exp_t;

    typedef struct {
        logic [7:0] win;
        logic [7:0] ew;
        logic       ewr;
    } vec_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Brute-force successor search, independent of the bit-trick datapath.
    function automatic logic [8:0] ref_next(input logic [7:0] w);
        int pc;
        int lo;
        if (w == 8'h00) return 9'h000;
        pc = $countones(w);
        for (int v = int'(w) + 1; v < 256; v++) begin
            logic [7:0] vb;
            vb = v[7:0];
            if ($countones(vb) == pc) return {1'b0, vb};
        end
        lo = (1 << pc) - 1;
        return {1'b1, lo[7:0]};
    endfunction

    always @(negedge clock) begin
        if (!clear && output_valid && output_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h with nothing expected", word_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_word", word_out, e.w);
                chk("sb_wrap", wrapped, e.wr);
            end
        end
    end

    task automatic send(input logic [7:0] w, input logic [7:0] ew, input logic ewr);
        int n;
        input_valid = 1'b1;
        word_in     = w;
        #1;
        n = 0;
        while (!input_ready && n < 50) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (!input_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: input_ready stuck at %0b for word %0h, expected 1", input_ready, w);
        end else begin
            sb.push_back('{ew, ewr});
        end
        @(posedge clock);
        #2;
        input_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock);
        #2;
    endtask

    vec_t       tbl[11];
    logic [8:0] r;
    logic [7:0] prev, w;

    initial begin
        tbl[0]  = '{8'h07, 8'h0B, 1'b0};
        tbl[1]  = '{8'h06, 8'h09, 1'b0};
        tbl[2]  = '{8'h80, 8'h01, 1'b1};
        tbl[3]  = '{8'hE0, 8'h07, 1'b1};
        tbl[4]  = '{8'hFF, 8'hFF, 1'b1};
        tbl[5]  = '{8'h00, 8'h00, 1'b0};
        tbl[6]  = '{8'h01, 8'h02, 1'b0};
        tbl[7]  = '{8'h0C, 8'h11, 1'b0};
        tbl[8]  = '{8'h5A, 8'h5C, 1'b0};
        tbl[9]  = '{8'h7F, 8'hBF, 1'b0};
        tbl[10] = '{8'hC0, 8'h03, 1'b1};

        clear        = 1'b1;
        input_valid  = 1'b0;
        word_in      = 8'h00;
        output_ready = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        clear = 1'b0;
        chk("rst_valid", output_valid, 1'b0);
        chk("rst_word", word_out, 8'h00);
        chk("rst_wrap", wrapped, 1'b0);
        chk("rst_ready", input_ready, 1'b1);

        // Each result must be valid one cycle after its accept.
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].win, tbl[i].ew, tbl[i].ewr);
            chk("lat_valid", output_valid, 1'b1);
        end
        idle();
        chk("drain_valid", output_valid, 1'b0);

        // Feed each result back in, starting from 0x03. This walks all 28 two-bit words and wraps.
        prev = 8'h03;
        w    = 8'h03;
        for (int k = 0; k < 28; k++) begin
            r = ref_next(w);
            send(w, r[7:0], r[8]);
            chk("chain_pc", $countones(word_out), 2);
            if (k < 27) begin
                chk("chain_inc", word_out > prev, 1'b1);
            end else begin
                chk("chain_last_word", word_out, 8'h03);
                chk("chain_last_wrap", wrapped, 1'b1);
            end
            prev = word_out;
            w    = word_out;
        end
        idle();

        // Stall the output for 5 cycles, then consume and accept on the same edge.
        output_ready = 1'b0;
        send(8'h07, 8'h0B, 1'b0);
        input_valid = 1'b1;
        word_in     = 8'h06;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_ready", input_ready, 1'b0);
            chk("bp_valid", output_valid, 1'b1);
            chk("bp_word", word_out, 8'h0B);
            @(posedge clock);
            #2;
        end
        output_ready = 1'b1;
        #1;
        chk("bp_release_ready", input_ready, 1'b1);
        sb.push_back('{8'h09, 1'b0});
        @(posedge clock);
        #2;
        input_valid = 1'b0;
        chk("bp_reload_valid", output_valid, 1'b1);
        chk("bp_reload_word", word_out, 8'h09);
        idle();

        // A clear wins over a pending accept and empties the output register.
        output_ready = 1'b0;
        send(8'h80, 8'h01, 1'b1);
        input_valid = 1'b1;
        word_in     = 8'hE0;
        clear       = 1'b1;
        @(posedge clock);
        #2;
        clear       = 1'b0;
        input_valid = 1'b0;
        #1;
        chk("clr_valid", output_valid, 1'b0);
        chk("clr_word", word_out, 8'h00);
        chk("clr_wrap", wrapped, 1'b0);
        chk("clr_ready", input_ready, 1'b1);
        sb.delete();
        output_ready = 1'b1;
        send(8'h0C, 8'h11, 1'b0);

        for (int n = 0; n < 20 && sb.size() != 0; n++) idle();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
